tx_port_fanout: RTL and testbench

- Sits directly downstream of the TX destination-lookup stage.
- Consumes one AXI-network packet stream that carries a per-packet destination port mask, and fans it out to NETH per-port outgoing streams.
- A beat is released upstream only once every selected port has accepted it.
- An all-zero mask means broadcast.
- A stall timeout evicts a hung port so one dead link cannot wedge the switch.

---
 rtl/tx_port_fanout.sv | 215 +++++++++++++++++++++
 tb/tb_tx_port_fanout.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_port_fanout.sv
// -----------------------------------------------------------------------------
// tx_port_fanout
//
// Fans one AXI-network packet stream out to NETH outgoing port streams. The
// destination mask rides on the first beat of each packet (all-zero means
// broadcast). A beat is held in a single output register stage and is only
// released upstream once every selected port has taken it. A port that makes
// no progress for TIMEOUT cycles is evicted from the packet with an abort
// strobe, so one dead link cannot stall the whole switch.
//
// Ports:
//   i_clk, i_reset_n   clock, asynchronous active-low reset
//   S_VALID/S_READY    input beat handshake
//   S_DATA, S_BYTES    beat payload and valid byte count (0 = full beat)
//   S_LAST             final beat of packet
//   S_ABORT            abort the current packet (valid with or without S_VALID)
//   S_PORT             destination mask, sampled on the first beat only
//   M_VALID/M_READY    per-port beat handshake
//   M_DATA, M_BYTES    shared beat payload and byte count
//   M_LAST             shared final-beat flag
//   M_ABORT            per-port one-cycle abort strobe
// -----------------------------------------------------------------------------
module tx_port_fanout #(
    parameter int NETH         = 4,
    parameter int DW           = 128,
    parameter int WBITS        = $clog2(DW/8),
    parameter int TIMEOUT      = 1024,
    parameter bit OPT_LOWPOWER = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             S_VALID,
    output logic             S_READY,
    input  logic [DW-1:0]    S_DATA,
    input  logic [WBITS-1:0] S_BYTES,
    input  logic             S_LAST,
    input  logic             S_ABORT,
    input  logic [NETH-1:0]  S_PORT,
    output logic [NETH-1:0]  M_VALID,
    input  logic [NETH-1:0]  M_READY,
    output logic [DW-1:0]    M_DATA,
    output logic [WBITS-1:0] M_BYTES,
    output logic             M_LAST,
    output logic [NETH-1:0]  M_ABORT
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DROP
    } state_t;

    state_t            state, state_next;
    logic [NETH-1:0]   pend, pend_next;     // ports still owing the held beat
    logic [NETH-1:0]   mask, mask_next;     // live destinations of the packet
    logic [NETH-1:0]   abort_q, abort_next;
    logic [CW-1:0]     stall_cnt, stall_next;
    logic              ready_en;            // keeps S_READY low during reset
    logic [DW-1:0]     m_data;
    logic [WBITS-1:0]  m_bytes;
    logic              m_last;

    logic              accept;
    logic              load;
    logic              in_abort;
    logic              stalled;
    logic              evict;
    logic [NETH-1:0]   first_mask;

    // Ready looks at what the held beat will owe after this cycle's
    // acceptances, so a beat taken by all its ports is replaced back-to-back.
    assign accept     = S_VALID && S_READY;
    assign in_abort   = S_ABORT && (state != ST_IDLE);
    assign load       = accept && !S_ABORT && (state != ST_DROP);
    assign first_mask = (S_PORT == '0) ? '1 : S_PORT;
    assign stalled    = (pend != '0) && ((pend & M_READY) == '0);
    assign evict      = (TIMEOUT != 0) && stalled
                        && (stall_cnt == CW'(TIMEOUT - 1));

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath next values.
    // NOTE: every target gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        pend_next  = pend & ~M_READY;
        mask_next  = mask;
        abort_next = '0;
        stall_next = stall_cnt;

        if (!stalled) begin
            stall_next = '0;
        end else if (stall_cnt != CW'(TIMEOUT)) begin
            stall_next = stall_cnt + 1'b1;
        end

        // Eviction needs pend != 0 and nothing accepted, which also holds
        // S_READY low, so it never coincides with a new load.
        if (evict) begin
            abort_next = pend;
            mask_next  = mask & ~pend;
            pend_next  = '0;
            stall_next = '0;
            if (state == ST_ACTIVE) begin
                if (m_last) begin
                    state_next = ST_IDLE;
                end else if ((mask & ~pend) == '0) begin
                    state_next = ST_DROP;
                end
            end
        end

        unique case (state)
            ST_IDLE: begin
                if (load) begin
                    mask_next  = first_mask;
                    pend_next  = first_mask;
                    state_next = S_LAST ? ST_IDLE : ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (load) begin
                    pend_next = mask;
                    if (S_LAST) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                if (accept && S_LAST) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Abort overrides everything; OR-ing with the eviction strobe keeps a
        // port that is both evicted and aborted to a single pulse.
        if (in_abort) begin
            abort_next = abort_next | mask;
            pend_next  = '0;
            mask_next  = '0;
            stall_next = '0;
            state_next = ST_IDLE;
        end
    end

    // Outputs.
    always_comb begin
        S_READY = ready_en
                  && ((state == ST_DROP) || ((pend & ~M_READY) == '0));
        M_VALID = pend;
        M_ABORT = abort_q;
        M_DATA  = m_data;
        M_BYTES = m_bytes;
        M_LAST  = m_last;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pend      <= '0;
            mask      <= '0;
            abort_q   <= '0;
            stall_cnt <= '0;
            ready_en  <= 1'b0;
        end else begin
            pend      <= pend_next;
            mask      <= mask_next;
            abort_q   <= abort_next;
            stall_cnt <= stall_next;
            ready_en  <= 1'b1;
        end
    end

    // NOTE: the beat payload needs no reset for correctness (M_VALID guards
    // it); it is only reset and cleared when the low-power option asks for
    // quiet data lines.
    if (OPT_LOWPOWER) begin : g_data_lp
        always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
                m_data  <= '0;
                m_bytes <= '0;
                m_last  <= 1'b0;
            end else if (load) begin
                m_data  <= S_DATA;
                m_bytes <= S_BYTES;
                m_last  <= S_LAST;
            end else if (in_abort || (pend_next == '0)) begin
                m_data  <= '0;
                m_bytes <= '0;
                m_last  <= 1'b0;
            end
        end
    end else begin : g_data_hold
        always_ff @(posedge i_clk) begin
            if (load) begin
                m_data  <= S_DATA;
                m_bytes <= S_BYTES;
                m_last  <= S_LAST;
            end
        end
    end

endmodule

// File: tb/tb_tx_port_fanout.sv
// -----------------------------------------------------------------------------
// tb_tx_port_fanout
//
// Directed bench for tx_port_fanout (NETH=4, DW=32, TIMEOUT=8, low-power
// data clearing on). Inputs change and registered outputs are observed on the
// falling clock edge; S_READY is observed 1 time unit after inputs settle.
// -----------------------------------------------------------------------------
module tb_tx_port_fanout;

    localparam int NETH  = 4;
    localparam int DW    = 32;
    localparam int WBITS = 2;

    logic             i_clk;
    logic             i_reset_n;
    logic             S_VALID;
    logic             S_READY;
    logic [DW-1:0]    S_DATA;
    logic [WBITS-1:0] S_BYTES;
    logic             S_LAST;
    logic             S_ABORT;
    logic [NETH-1:0]  S_PORT;
    logic [NETH-1:0]  M_VALID;
    logic [NETH-1:0]  M_READY;
    logic [DW-1:0]    M_DATA;
    logic [WBITS-1:0] M_BYTES;
    logic             M_LAST;
    logic [NETH-1:0]  M_ABORT;

    int checks = 0;
    int errors = 0;

    tx_port_fanout #(
        .NETH(NETH), .DW(DW), .WBITS(WBITS), .TIMEOUT(8), .OPT_LOWPOWER(1'b1)
    ) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA),
        .S_BYTES(S_BYTES), .S_LAST(S_LAST), .S_ABORT(S_ABORT), .S_PORT(S_PORT),
        .M_VALID(M_VALID), .M_READY(M_READY), .M_DATA(M_DATA),
        .M_BYTES(M_BYTES), .M_LAST(M_LAST), .M_ABORT(M_ABORT)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic drive(input logic [DW-1:0] d, input logic [WBITS-1:0] b,
                         input logic last, input logic [NETH-1:0] port);
        S_VALID = 1'b1;
        S_DATA  = d;
        S_BYTES = b;
        S_LAST  = last;
        S_PORT  = port;
    endtask

    task automatic idle_in();
        S_VALID = 1'b0;
        S_ABORT = 1'b0;
        S_DATA  = '0;
        S_BYTES = '0;
        S_LAST  = 1'b0;
        S_PORT  = '0;
    endtask

    task automatic test_reset();
        idle_in();
        M_READY   = '1;
        i_reset_n = 1'b0;
        tick();
        tick();
        checks++; if (M_VALID !== 4'b0000) begin errors++; $display("FAIL rst_valid: got %b want 0000", M_VALID); end
        checks++; if (M_ABORT !== 4'b0000) begin errors++; $display("FAIL rst_abort: got %b want 0000", M_ABORT); end
        checks++; if (S_READY !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", S_READY); end
        checks++; if ({M_DATA, M_BYTES, M_LAST} !== '0) begin errors++; $display("FAIL rst_data: got %h/%h/%b want 0", M_DATA, M_BYTES, M_LAST); end
        i_reset_n = 1'b1;
        tick();
        tick();
        checks++; if (S_READY !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b want 1", S_READY); end
    endtask

    task automatic test_unicast();
        logic [DW-1:0] d [3] = '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
        M_READY = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            drive(d[i], (i == 2) ? 2'd3 : 2'd0, i == 2, (i == 0) ? 4'b0100 : 4'b1111);
            #1;
            checks++; if (S_READY !== 1'b1) begin errors++; $display("FAIL uni_ready%0d: got %b want 1", i, S_READY); end
            tick();
            checks++; if (M_VALID !== 4'b0100) begin errors++; $display("FAIL uni_valid%0d: got %b want 0100", i, M_VALID); end
            checks++; if (M_DATA !== d[i]) begin errors++; $display("FAIL uni_data%0d: got %h want %h", i, M_DATA, d[i]); end
            checks++; if (M_LAST !== (i == 2)) begin errors++; $display("FAIL uni_last%0d: got %b want %b", i, M_LAST, i == 2); end
        end
        checks++; if (M_BYTES !== 2'd3) begin errors++; $display("FAIL uni_bytes: got %0d want 3", M_BYTES); end
        idle_in();
        tick();
        checks++; if (M_VALID !== 4'b0000) begin errors++; $display("FAIL uni_drain: got %b want 0000", M_VALID); end
        checks++; if (M_DATA !== '0) begin errors++; $display("FAIL uni_lowpower: got %h want 0", M_DATA); end
    endtask

    task automatic test_broadcast();
        M_READY = 4'b0111;
        drive(32'hB000_0001, 2'd0, 1'b0, 4'b0000);
        tick();
        checks++; if (M_VALID !== 4'b1111) begin errors++; $display("FAIL bc_valid1: got %b want 1111", M_VALID); end
        drive(32'hB000_0002, 2'd1, 1'b1, 4'b0000);
        #1;
        checks++; if (S_READY !== 1'b0) begin errors++; $display("FAIL bc_ready_hold: got %b want 0", S_READY); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (M_VALID !== 4'b1000) begin errors++; $display("FAIL bc_stall%0d: got %b want 1000", i, M_VALID); end
            if (i == 4) M_READY = 4'b1111;
            #1;
            checks++; if (S_READY !== (i == 4)) begin errors++; $display("FAIL bc_ready%0d: got %b want %b", i, S_READY, i == 4); end
        end
        tick();
        checks++; if (M_VALID !== 4'b1111) begin errors++; $display("FAIL bc_valid2: got %b want 1111", M_VALID); end
        checks++; if (M_DATA !== 32'hB000_0002) begin errors++; $display("FAIL bc_data2: got %h want b0000002", M_DATA); end
        checks++; if (M_LAST !== 1'b1) begin errors++; $display("FAIL bc_last: got %b want 1", M_LAST); end
        idle_in();
        tick();
        checks++; if (M_VALID !== 4'b0000) begin errors++; $display("FAIL bc_drain: got %b want 0000", M_VALID); end
    endtask

    task automatic test_abort();
        M_READY = 4'b1111;
        drive(32'hC000_0001, 2'd0, 1'b0, 4'b0011);
        tick();
        checks++; if (M_VALID !== 4'b0011) begin errors++; $display("FAIL ab_valid1: got %b want 0011", M_VALID); end
        drive(32'hC000_0002, 2'd0, 1'b0, 4'b0000);
        tick();
        checks++; if (M_VALID !== 4'b0011) begin errors++; $display("FAIL ab_valid2: got %b want 0011", M_VALID); end
        idle_in();
        M_READY = 4'b0001;
        tick();
        checks++; if (M_VALID !== 4'b0010) begin errors++; $display("FAIL ab_pend: got %b want 0010", M_VALID); end
        S_ABORT = 1'b1;
        tick();
        checks++; if (M_ABORT !== 4'b0011) begin errors++; $display("FAIL ab_strobe: got %b want 0011", M_ABORT); end
        checks++; if (M_VALID !== 4'b0000) begin errors++; $display("FAIL ab_valid_clr: got %b want 0000", M_VALID); end
        checks++; if (M_DATA !== '0) begin errors++; $display("FAIL ab_lowpower: got %h want 0", M_DATA); end
        S_ABORT = 1'b0;
        tick();
        checks++; if (M_ABORT !== 4'b0000) begin errors++; $display("FAIL ab_strobe_once: got %b want 0000", M_ABORT); end
        M_READY = 4'b1111;
        drive(32'hD000_0001, 2'd0, 1'b1, 4'b0001);
        tick();
        checks++; if (M_VALID !== 4'b0001) begin errors++; $display("FAIL ab_next_valid: got %b want 0001", M_VALID); end
        checks++; if (M_DATA !== 32'hD000_0001) begin errors++; $display("FAIL ab_next_data: got %h want d0000001", M_DATA); end
        idle_in();
        tick();
    endtask

    task automatic test_timeout();
        M_READY = 4'b1011;
        drive(32'hE000_0001, 2'd0, 1'b0, 4'b0110);
        tick();
        checks++; if (M_VALID !== 4'b0110) begin errors++; $display("FAIL to_valid1: got %b want 0110", M_VALID); end
        drive(32'hE000_0002, 2'd0, 1'b0, 4'b0000);
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (M_VALID !== 4'b0100 || M_ABORT !== 4'b0000) begin errors++; $display("FAIL to_stall%0d: got %b/%b want 0100/0000", i, M_VALID, M_ABORT); end
        end
        tick();
        checks++; if (M_ABORT !== 4'b0100) begin errors++; $display("FAIL to_evict: got %b want 0100", M_ABORT); end
        checks++; if (M_VALID !== 4'b0000) begin errors++; $display("FAIL to_evict_valid: got %b want 0000", M_VALID); end
        tick();
        checks++; if (M_ABORT !== 4'b0000) begin errors++; $display("FAIL to_evict_once: got %b want 0000", M_ABORT); end
        checks++; if (M_VALID !== 4'b0010) begin errors++; $display("FAIL to_valid2: got %b want 0010", M_VALID); end
        checks++; if (M_DATA !== 32'hE000_0002) begin errors++; $display("FAIL to_data2: got %h want e0000002", M_DATA); end
        drive(32'hE000_0003, 2'd0, 1'b1, 4'b0000);
        tick();
        checks++; if (M_VALID !== 4'b0010 || M_LAST !== 1'b1) begin errors++; $display("FAIL to_last: got %b/%b want 0010/1", M_VALID, M_LAST); end
        idle_in();
        M_READY = 4'b1111;
        tick();
        checks++; if (M_VALID !== 4'b0000) begin errors++; $display("FAIL to_drain: got %b want 0000", M_VALID); end
    endtask

    task automatic test_full_evict();
        M_READY = 4'b1110;
        drive(32'hF000_0001, 2'd0, 1'b0, 4'b0001);
        tick();
        checks++; if (M_VALID !== 4'b0001) begin errors++; $display("FAIL fe_valid: got %b want 0001", M_VALID); end
        drive(32'hF000_0002, 2'd0, 1'b0, 4'b0000);
        for (int i = 0; i < 8; i++) tick();
        checks++; if (M_ABORT !== 4'b0001) begin errors++; $display("FAIL fe_evict: got %b want 0001", M_ABORT); end
        #1;
        checks++; if (S_READY !== 1'b1) begin errors++; $display("FAIL fe_drop_ready: got %b want 1", S_READY); end
        tick();
        checks++; if (M_VALID !== 4'b0000 || M_ABORT !== 4'b0000) begin errors++; $display("FAIL fe_drop_quiet: got %b/%b want 0000/0000", M_VALID, M_ABORT); end
        drive(32'hF000_0003, 2'd0, 1'b1, 4'b0000);
        #1;
        checks++; if (S_READY !== 1'b1) begin errors++; $display("FAIL fe_drop_ready2: got %b want 1", S_READY); end
        tick();
        checks++; if (M_VALID !== 4'b0000) begin errors++; $display("FAIL fe_drop_last: got %b want 0000", M_VALID); end
        M_READY = 4'b1111;
        drive(32'h1234_5678, 2'd0, 1'b1, 4'b0001);
        tick();
        checks++; if (M_VALID !== 4'b0001) begin errors++; $display("FAIL fe_idle_again: got %b want 0001", M_VALID); end
        idle_in();
        tick();
    endtask

    task automatic test_async_reset();
        M_READY = 4'b1101;
        drive(32'h0A0A_0A0A, 2'd0, 1'b0, 4'b0010);
        tick();
        checks++; if (M_VALID !== 4'b0010) begin errors++; $display("FAIL ar_valid: got %b want 0010", M_VALID); end
        idle_in();
        #2 i_reset_n = 1'b0;
        #1;
        checks++; if (M_VALID !== 4'b0000) begin errors++; $display("FAIL ar_valid_now: got %b want 0000", M_VALID); end
        checks++; if (S_READY !== 1'b0) begin errors++; $display("FAIL ar_ready_now: got %b want 0", S_READY); end
        tick();
        i_reset_n = 1'b1;
        M_READY   = 4'b1111;
        tick();
        drive(32'h0B0B_0B0B, 2'd2, 1'b1, 4'b1000);
        #1;
        checks++; if (S_READY !== 1'b1) begin errors++; $display("FAIL ar_ready_after: got %b want 1", S_READY); end
        tick();
        checks++; if (M_VALID !== 4'b1000 || M_DATA !== 32'h0B0B_0B0B || M_BYTES !== 2'd2) begin errors++; $display("FAIL ar_fresh: got %b/%h/%0d want 1000/0b0b0b0b/2", M_VALID, M_DATA, M_BYTES); end
        idle_in();
        tick();
        checks++; if (M_VALID !== 4'b0000 || M_ABORT !== 4'b0000) begin errors++; $display("FAIL ar_drain: got %b/%b want 0000/0000", M_VALID, M_ABORT); end
    endtask

    initial begin
        test_reset();
        test_unicast();
        test_broadcast();
        test_abort();
        test_timeout();
        test_full_evict();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
